// File: rtl/trap_controller_pkg.sv
// -----------------------------------------------------------------------------
// trap_controller_pkg
//   Shared RISC-V trap types for the trap controller: privilege modes,
//   exception and interrupt codes, the trap FSM state, the mtvec mode
//   encodings, the registered trap request record and the fixed interrupt
//   priority order.
//   Configuration macro used by the importing RTL: RAFI_TRAP_VECTORED_EN.
// -----------------------------------------------------------------------------
package trap_controller_pkg;

    localparam int RV_XLEN    = 32;
    localparam int RV_INT_NUM = 12;

    typedef enum logic [1:0] {
        Privilege_User       = 2'b00,
        Privilege_Supervisor = 2'b01,
        Privilege_Reserved   = 2'b10,
        Privilege_Machine    = 2'b11
    } Privilege;

    typedef enum logic [3:0] {
        ExceptionCode_InsnAddrMisaligned  = 4'd0,
        ExceptionCode_InsnAccessFault     = 4'd1,
        ExceptionCode_IllegalInsn         = 4'd2,
        ExceptionCode_Breakpoint          = 4'd3,
        ExceptionCode_LoadAddrMisaligned  = 4'd4,
        ExceptionCode_LoadAccessFault     = 4'd5,
        ExceptionCode_StoreAddrMisaligned = 4'd6,
        ExceptionCode_StoreAccessFault    = 4'd7,
        ExceptionCode_EnvCallFromU        = 4'd8,
        ExceptionCode_EnvCallFromS        = 4'd9,
        ExceptionCode_EnvCallFromM        = 4'd11,
        ExceptionCode_InsnPageFault       = 4'd12,
        ExceptionCode_LoadPageFault       = 4'd13,
        ExceptionCode_StorePageFault      = 4'd15
    } ExceptionCode;

    typedef enum logic [3:0] {
        InterruptCode_UserSoftware       = 4'd0,
        InterruptCode_SupervisorSoftware = 4'd1,
        InterruptCode_MachineSoftware    = 4'd3,
        InterruptCode_UserTimer          = 4'd4,
        InterruptCode_SupervisorTimer    = 4'd5,
        InterruptCode_MachineTimer       = 4'd7,
        InterruptCode_UserExternal       = 4'd8,
        InterruptCode_SupervisorExternal = 4'd9,
        InterruptCode_MachineExternal    = 4'd11
    } InterruptCode;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        REQUEST = 2'd2
    } TrapState;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // Trap decision frozen when leaving IDLE; later mip/mie changes cannot touch it.
    typedef struct packed {
        logic                isInterrupt;
        logic [3:0]          code;
        logic [RV_XLEN-1:0]  epc;
        logic [RV_XLEN-1:0]  tval;
    } trap_req_t;

    // Highest priority first.
    localparam InterruptCode INT_PRIORITY [9] = '{
        InterruptCode_MachineExternal,
        InterruptCode_MachineSoftware,
        InterruptCode_MachineTimer,
        InterruptCode_SupervisorExternal,
        InterruptCode_SupervisorSoftware,
        InterruptCode_SupervisorTimer,
        InterruptCode_UserExternal,
        InterruptCode_UserSoftware,
        InterruptCode_UserTimer
    };

endpackage

// File: rtl/trap_controller_interrupt_priority_encoder.sv
// -----------------------------------------------------------------------------
// interrupt_priority_encoder
//   Combinational: masks pending interrupts with their enables and returns
//   the highest-priority interrupt code (MEI > MSI > MTI > SEI > SSI > STI >
//   UEI > USI > UTI). Reserved bit positions never produce a request.
//   Ports:
//     i_mip    [INT_NUM]  pending interrupt vector
//     i_mie    [INT_NUM]  interrupt enable vector
//     o_valid            at least one enabled, pending interrupt
//     o_code             InterruptCode of the winner (USI when none)
// -----------------------------------------------------------------------------
module interrupt_priority_encoder
    import trap_controller_pkg::*;
#(
    parameter int INT_NUM = RV_INT_NUM
) (
    input  logic [INT_NUM-1:0] i_mip,
    input  logic [INT_NUM-1:0] i_mie,
    output logic               o_valid,
    output InterruptCode       o_code
);

    logic [INT_NUM-1:0] w_pending;

    assign w_pending = i_mip & i_mie;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
        o_valid = 1'b0;
        o_code  = InterruptCode_UserSoftware;
        for (int i = 8; i >= 0; i--) begin
            if (w_pending[INT_PRIORITY[i]]) begin
                o_valid = 1'b1;
                o_code  = INT_PRIORITY[i];
            end
        end
    end

endmodule

// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
//   Turns a committed exception or an eligible interrupt into a single
//   trap-entry request for the CSR file and fetch redirect: chooses the
//   cause, builds mcause/mepc/mtval and the handler PC from mtvec.
//   Flow: IDLE -> CAPTURE (1 cycle, excAck pulse for exceptions) ->
//   REQUEST (trapValid held until trapReady) -> IDLE.
//   Configuration macro: RAFI_TRAP_VECTORED_EN -- when defined, mtvec mode
//   01 sends interrupts to base + 4*code; otherwise every trap uses base.
//   Ports:
//     clk, rstN                       clock, async active-low reset
//     excValid/excCode/excPc/excTval  exception report (held until excAck)
//     excAck                          one-cycle capture pulse
//     mip, mie, mstatusMie, priv      interrupt state from the CSR file
//     mtvec                           trap vector base and mode
//     trapValid/trapReady             trap-entry handshake
//     trapPc/trapCause/trapEpc/trapTval  handler PC, mcause, mepc, mtval
//     busy                            high outside IDLE; commit must stall
// -----------------------------------------------------------------------------
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int XLEN    = RV_XLEN,
    parameter int INT_NUM = RV_INT_NUM
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               excValid,
    input  logic [3:0]         excCode,
    input  logic [XLEN-1:0]    excPc,
    input  logic [XLEN-1:0]    excTval,
    output logic               excAck,
    input  logic [INT_NUM-1:0] mip,
    input  logic [INT_NUM-1:0] mie,
    input  logic               mstatusMie,
    input  logic [1:0]         priv,
    input  logic [XLEN-1:0]    mtvec,
    output logic               trapValid,
    input  logic               trapReady,
    output logic [XLEN-1:0]    trapPc,
    output logic [XLEN-1:0]    trapCause,
    output logic [XLEN-1:0]    trapEpc,
    output logic [XLEN-1:0]    trapTval,
    output logic               busy
);

    TrapState          r_state;
    trap_req_t         r_req;
    logic              r_exc_ack;
    logic              r_trap_valid;
    logic              r_busy;
    logic [XLEN-1:0]   r_trap_pc;
    logic [XLEN-1:0]   r_trap_cause;
    logic [XLEN-1:0]   r_trap_epc;
    logic [XLEN-1:0]   r_trap_tval;

    logic              w_int_valid;
    InterruptCode      w_int_code;
    logic              w_int_enabled;
    logic              w_int_take;
    logic [XLEN-1:0]   w_base;
    logic [XLEN-1:0]   w_trap_pc;

    interrupt_priority_encoder #(
        .INT_NUM (INT_NUM)
    ) u_int_enc (
        .i_mip   (mip),
        .i_mie   (mie),
        .o_valid (w_int_valid),
        .o_code  (w_int_code)
    );

    // Below machine mode interrupts are always taken; in M-mode mstatus.MIE gates them.
    assign w_int_enabled = (priv != Privilege_Machine) || mstatusMie;
    assign w_int_take    = w_int_valid && w_int_enabled;

    assign w_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef RAFI_TRAP_VECTORED_EN
    // Reserved modes 10/11 fall through to direct.
    assign w_trap_pc = (r_req.isInterrupt && (mtvec[1:0] == MTVEC_MODE_VECTORED))
                     ? w_base + {{(XLEN-6){1'b0}}, r_req.code, 2'b00}
                     : w_base;
`else
    logic w_unused_mode;
    assign w_unused_mode = ^mtvec[1:0];
    assign w_trap_pc     = w_base;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state      <= IDLE;
            r_req        <= '0;
            r_exc_ack    <= 1'b0;
            r_trap_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_trap_pc    <= '0;
            r_trap_cause <= '0;
            r_trap_epc   <= '0;
            r_trap_tval  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; this default makes excAck a single-cycle pulse.
            r_exc_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    // An exception outranks an interrupt arriving in the same cycle.
                    if (excValid) begin
                        r_req.isInterrupt <= 1'b0;
                        r_req.code        <= excCode;
                        r_req.epc         <= {excPc[XLEN-1:2], 2'b00};
                        r_req.tval        <= excTval;
                        r_exc_ack         <= 1'b1;
                        r_busy            <= 1'b1;
                        r_state           <= CAPTURE;
                    end else if (w_int_take) begin
                        r_req.isInterrupt <= 1'b1;
                        r_req.code        <= w_int_code;
                        r_req.epc         <= {excPc[XLEN-1:2], 2'b00};
                        r_req.tval        <= '0;
                        r_busy            <= 1'b1;
                        r_state           <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_trap_pc    <= w_trap_pc;
                    r_trap_cause <= {r_req.isInterrupt, {(XLEN-5){1'b0}}, r_req.code};
                    r_trap_epc   <= r_req.epc;
                    r_trap_tval  <= r_req.tval;
                    r_trap_valid <= 1'b1;
                    r_state      <= REQUEST;
                end
                REQUEST: begin
                    if (trapReady) begin
                        r_trap_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_trap_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign excAck    = r_exc_ack;
    assign trapValid = r_trap_valid;
    assign busy      = r_busy;
    assign trapPc    = r_trap_pc;
    assign trapCause = r_trap_cause;
    assign trapEpc   = r_trap_epc;
    assign trapTval  = r_trap_tval;

endmodule

// File: tb/tb_trap_controller.sv
// -----------------------------------------------------------------------------
// tb_trap_controller
//   Directed bench for trap_controller. Inputs change 1 time unit after the
//   rising edge and outputs are compared at that same point, i.e. they show
//   the state registered at the edge just passed.
//   Honours RAFI_TRAP_VECTORED_EN for the vectored handler-PC expectations.
// -----------------------------------------------------------------------------
module tb_trap_controller;

    localparam int XLEN    = 32;
    localparam int INT_NUM = 12;

`ifdef RAFI_TRAP_VECTORED_EN
    localparam logic [31:0] EXP_MTI_VEC_PC = 32'h0000_801C;
`else
    localparam logic [31:0] EXP_MTI_VEC_PC = 32'h0000_8000;
`endif

    logic               clk = 1'b0;
    logic               rstN;
    logic               excValid;
    logic [3:0]         excCode;
    logic [XLEN-1:0]    excPc;
    logic [XLEN-1:0]    excTval;
    logic               excAck;
    logic [INT_NUM-1:0] mip;
    logic [INT_NUM-1:0] mie;
    logic               mstatusMie;
    logic [1:0]         priv;
    logic [XLEN-1:0]    mtvec;
    logic               trapValid;
    logic               trapReady;
    logic [XLEN-1:0]    trapPc;
    logic [XLEN-1:0]    trapCause;
    logic [XLEN-1:0]    trapEpc;
    logic [XLEN-1:0]    trapTval;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trap_controller #(
        .XLEN    (XLEN),
        .INT_NUM (INT_NUM)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .excValid   (excValid),
        .excCode    (excCode),
        .excPc      (excPc),
        .excTval    (excTval),
        .excAck     (excAck),
        .mip        (mip),
        .mie        (mie),
        .mstatusMie (mstatusMie),
        .priv       (priv),
        .mtvec      (mtvec),
        .trapValid  (trapValid),
        .trapReady  (trapReady),
        .trapPc     (trapPc),
        .trapCause  (trapCause),
        .trapEpc    (trapEpc),
        .trapTval   (trapTval),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_req(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] epc, input logic [31:0] tval);
        check({tag, ".valid"}, {31'd0, trapValid}, 32'd1);
        check({tag, ".busy"},  {31'd0, busy},      32'd1);
        check({tag, ".pc"},    trapPc,    pc);
        check({tag, ".cause"}, trapCause, cause);
        check({tag, ".epc"},   trapEpc,   epc);
        check({tag, ".tval"},  trapTval,  tval);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, {31'd0, trapValid}, 32'd0);
        check({tag, ".busy"},  {31'd0, busy},      32'd0);
    endtask

    initial begin
        rstN       = 1'b0;
        excValid   = 1'b0;
        excCode    = 4'd0;
        excPc      = '0;
        excTval    = '0;
        mip        = '0;
        mie        = '0;
        mstatusMie = 1'b0;
        priv       = 2'b11;
        mtvec      = 32'h0000_8000;
        trapReady  = 1'b0;

        // ---- reset state
        tick();
        tick();
        check_idle("rst");
        check("rst.ack",   {31'd0, excAck}, 32'd0);
        check("rst.pc",    trapPc,    32'd0);
        check("rst.cause", trapCause, 32'd0);
        check("rst.epc",   trapEpc,   32'd0);
        check("rst.tval",  trapTval,  32'd0);
        rstN = 1'b1;
        tick();
        check_idle("post_rst");

        // ---- 1: IllegalInsn exception, latency and excAck pulse
        excValid = 1'b1;
        excCode  = 4'd2;
        excPc    = 32'h0000_0100;
        excTval  = 32'h0000_DEAD;
        tick();                                   // N+1: CAPTURE
        check("t1.ack_n1",   {31'd0, excAck},    32'd1);
        check("t1.busy_n1",  {31'd0, busy},      32'd1);
        check("t1.valid_n1", {31'd0, trapValid}, 32'd0);
        excValid = 1'b0;
        tick();                                   // N+2: REQUEST
        check("t1.ack_n2", {31'd0, excAck}, 32'd0);
        check_req("t1", 32'h0000_8000, 32'h0000_0002, 32'h0000_0100, 32'h0000_DEAD);
        trapReady = 1'b1;
        tick();                                   // N+3: IDLE
        trapReady = 1'b0;
        check_idle("t1.done");

        // ---- 4: consumer stalls for 5 cycles; misaligned excPc gets epc[1:0] cleared
        excValid = 1'b1;
        excCode  = 4'd5;
        excPc    = 32'h0000_0203;
        excTval  = 32'h0000_0044;
        tick();
        excValid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_req("t4.hold", 32'h0000_8000, 32'h0000_0005, 32'h0000_0200, 32'h0000_0044);
            tick();
        end
        check_req("t4.hold_end", 32'h0000_8000, 32'h0000_0005, 32'h0000_0200, 32'h0000_0044);
        trapReady = 1'b1;
        tick();
        trapReady = 1'b0;
        check_idle("t4.done");

        // ---- 2: MEI wins among 0x888; M-mode gating by mstatusMie
        mip        = 12'h888;
        mie        = 12'h888;
        mstatusMie = 1'b1;
        priv       = 2'b11;
        excPc      = 32'h0000_0304;
        tick();
        check("t2.ack",  {31'd0, excAck}, 32'd0);
        check("t2.busy", {31'd0, busy},   32'd1);
        tick();
        check_req("t2.mei", 32'h0000_8000, 32'h8000_000B, 32'h0000_0304, 32'h0000_0000);
        trapReady  = 1'b1;
        mstatusMie = 1'b0;
        tick();
        trapReady = 1'b0;
        tick();
        tick();
        tick();
        check_idle("t2.masked");
        priv = 2'b00;                             // U-mode: taken despite mstatusMie=0
        tick();
        check("t2.u_busy", {31'd0, busy}, 32'd1);
        tick();
        check_req("t2.u", 32'h0000_8000, 32'h8000_000B, 32'h0000_0304, 32'h0000_0000);
        mip       = '0;
        mie       = '0;
        priv      = 2'b11;
        trapReady = 1'b1;
        tick();
        trapReady = 1'b0;
        tick();
        check_idle("t2.done");

        // ---- 3: exception beats simultaneous MTI; MTI follows, frozen at capture
        mip        = 12'h080;
        mie        = 12'h080;
        mstatusMie = 1'b1;
        excValid   = 1'b1;
        excCode    = 4'd4;
        excPc      = 32'h0000_0400;
        excTval    = 32'h0000_0401;
        tick();
        check("t3.ack", {31'd0, excAck}, 32'd1);
        excValid = 1'b0;
        tick();
        check_req("t3.exc", 32'h0000_8000, 32'h0000_0004, 32'h0000_0400, 32'h0000_0401);
        trapReady = 1'b1;
        tick();
        trapReady = 1'b0;
        check_idle("t3.between");
        tick();                                   // MTI captured
        check("t3.int_ack",  {31'd0, excAck}, 32'd0);
        check("t3.int_busy", {31'd0, busy},   32'd1);
        mip = '0;                                 // must not alter the captured request
        mie = '0;
        tick();
        check_req("t3.mti", 32'h0000_8000, 32'h8000_0007, 32'h0000_0400, 32'h0000_0000);
        trapReady = 1'b1;
        tick();
        trapReady = 1'b0;
        tick();
        check_idle("t3.done");

        // ---- 5: mtvec mode handling, unknown exception code pass-through
        mtvec = 32'h0000_8001;
        mip   = 12'h080;
        mie   = 12'h080;
        tick();
        mip = '0;
        mie = '0;
        tick();
        check_req("t5.mti_vec", EXP_MTI_VEC_PC, 32'h8000_0007, 32'h0000_0400, 32'h0000_0000);
        trapReady = 1'b1;
        tick();
        trapReady = 1'b0;
        excValid = 1'b1;
        excCode  = 4'hD;
        excPc    = 32'h0000_0500;
        excTval  = 32'h1234_5678;
        tick();
        excValid = 1'b0;
        tick();
        check_req("t5.lpf", 32'h0000_8000, 32'h0000_000D, 32'h0000_0500, 32'h1234_5678);
        trapReady = 1'b1;
        tick();
        trapReady = 1'b0;
        mtvec = 32'h0000_8002;                    // reserved mode behaves as direct
        mip   = 12'h800;
        mie   = 12'h800;
        tick();
        mip = '0;
        mie = '0;
        tick();
        check_req("t5.reserved", 32'h0000_8000, 32'h8000_000B, 32'h0000_0500, 32'h0000_0000);
        trapReady = 1'b1;
        tick();
        trapReady = 1'b0;
        mtvec    = 32'h0000_8000;
        excValid = 1'b1;
        excCode  = 4'hA;
        excPc    = 32'h0000_0600;
        excTval  = 32'h0000_0000;
        tick();
        excValid = 1'b0;
        tick();
        check_req("t5.unknown_code", 32'h0000_8000, 32'h0000_000A, 32'h0000_0600, 32'h0000_0000);
        trapReady = 1'b1;
        tick();
        trapReady = 1'b0;
        tick();
        check_idle("t5.done");

        // ---- 6: async reset in REQUEST, no replay afterwards
        excValid = 1'b1;
        excCode  = 4'd2;
        excPc    = 32'h0000_0700;
        excTval  = 32'h0000_00AA;
        tick();
        excValid = 1'b0;
        tick();
        check("t6.pre_valid", {31'd0, trapValid}, 32'd1);
        rstN = 1'b0;
        #1;
        check_idle("t6.in_rst");
        check("t6.cause", trapCause, 32'd0);
        check("t6.pc",    trapPc,    32'd0);
        tick();
        rstN = 1'b1;
        tick();
        tick();
        tick();
        check_idle("t6.no_replay");
        check("t6.ack", {31'd0, excAck}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
